// File: rtl/l1_rd_rsp_if.sv
// L1 read-response handshake bundle: address issue side and AFU response side.
// master drives requests and response-ready; slave is the l1_rd_rsp block.
interface l1_rd_rsp_if #(
  parameter int nstrms_width = 6,
  parameter int ptr_width    = 1,
  parameter int data_width   = 64
);
  logic                    i_addr_v;
  logic                    i_addr_r;
  logic [ptr_width-1:0]    i_addr_ptr;
  logic [nstrms_width-1:0] i_addr_sid;
  logic                    i_addr_discard;
  logic                    o_rsp_v;
  logic                    o_rsp_r;
  logic [data_width-1:0]   o_rsp_d;
  logic [nstrms_width-1:0] o_rsp_sid;
  logic                    o_rsp_discard;

  modport master (
    output i_addr_v, i_addr_ptr, i_addr_sid, i_addr_discard, o_rsp_r,
    input  i_addr_r, o_rsp_v, o_rsp_d, o_rsp_sid, o_rsp_discard
  );

  modport slave (
    input  i_addr_v, i_addr_ptr, i_addr_sid, i_addr_discard, o_rsp_r,
    output i_addr_r, o_rsp_v, o_rsp_d, o_rsp_sid, o_rsp_discard
  );
endinterface

// File: rtl/l1_rd_rsp.sv
// L1 read-port response path: BRAM issue, latency tag pipe, credit-guarded FIFO.
// Optional macro RD_RSP_DISCARD_EN: discarded requests skip BRAM, return tagged.
module l1_rd_rsp #(
  parameter int nstrms       = 64,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int ptr_width    = 1,
  parameter int data_width   = 64,
  parameter int rd_lat       = 2,
  parameter int fifo_depth   = rd_lat + 2,
  parameter int cnt_width    = $clog2(fifo_depth + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  l1_rd_rsp_if.slave                        io_rd,
  output logic                              o_bram_re,
  output logic [nstrms_width+ptr_width-1:0] o_bram_addr,
  input  logic [data_width-1:0]             i_bram_d,
  output logic [cnt_width-1:0]              o_inflight
);
  localparam int aw = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [cnt_width-1:0] depth_c = cnt_width'(fifo_depth);
  localparam logic [aw-1:0] last_c = aw'(fifo_depth - 1);

  logic                    r_addr_r;
  logic [cnt_width-1:0]    r_inflight;
  logic [cnt_width-1:0]    r_cnt;
  logic [cnt_width-1:0]    w_inf_nxt;
  logic [rd_lat-1:0]       r_pv;
  logic [nstrms_width-1:0] r_psid [rd_lat];
  logic [data_width-1:0]   r_md [fifo_depth];
  logic [nstrms_width-1:0] r_ms [fifo_depth];
  logic [aw-1:0]           r_rd;
  logic [aw-1:0]           r_wr;
  logic                    w_acc;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_full;
  logic                    w_dis;
  logic                    w_push_dis;
  logic [data_width-1:0]   w_push_d;

  function automatic logic [aw-1:0] f_inc(input logic [aw-1:0] p);
    return (p == last_c) ? '0 : p + aw'(1);
  endfunction

`ifdef RD_RSP_DISCARD_EN
  logic [rd_lat-1:0]     r_pd;
  logic [fifo_depth-1:0] r_mdis;

  assign w_dis               = io_rd.i_addr_discard;
  assign w_push_dis          = r_pd[rd_lat-1];
  assign io_rd.o_rsp_discard = r_mdis[r_rd];

  // discard tag travels alongside the valid bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pd <= '0;
    end else begin
      r_pd[0] <= w_acc & w_dis;
      for (int i = 1; i < rd_lat; i++) r_pd[i] <= r_pd[i-1];
    end
  end

  // discard flag storage per FIFO entry
  always_ff @(posedge clk) begin
    if (reset) r_mdis <= '0;
    else if (w_push) r_mdis[r_wr] <= w_push_dis;
  end
`else
  assign w_dis               = 1'b0;
  assign w_push_dis          = 1'b0;
  assign io_rd.o_rsp_discard = 1'b0;
`endif

  assign w_acc            = io_rd.i_addr_v & r_addr_r;
  assign w_pop            = io_rd.o_rsp_v & io_rd.o_rsp_r;
  assign w_push           = r_pv[rd_lat-1];
  assign w_full           = (r_cnt == depth_c);
  assign w_push_d         = w_push_dis ? '0 : i_bram_d;
  assign o_bram_re        = w_acc & ~w_dis;
  assign o_bram_addr      = w_acc ? {io_rd.i_addr_sid, io_rd.i_addr_ptr} : '0;
  assign io_rd.i_addr_r   = r_addr_r;
  assign io_rd.o_rsp_v    = (r_cnt != '0);
  assign io_rd.o_rsp_d    = r_md[r_rd];
  assign io_rd.o_rsp_sid  = r_ms[r_rd];
  assign o_inflight       = r_inflight;

  // next credit count: accept adds, pop returns
  always_comb begin
    w_inf_nxt = r_inflight;
    if (w_acc & ~w_pop) w_inf_nxt = r_inflight + cnt_width'(1);
    else if (~w_acc & w_pop) w_inf_nxt = r_inflight - cnt_width'(1);
  end

  // credit counter and registered ready
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
      r_addr_r   <= 1'b0;
    end else begin
      r_inflight <= w_inf_nxt;
      r_addr_r   <= (w_inf_nxt < depth_c);
    end
  end

  // tag pipe mirrors the fixed BRAM latency
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv <= '0;
      for (int i = 0; i < rd_lat; i++) r_psid[i] <= '0;
    end else begin
      r_pv[0]   <= w_acc;
      r_psid[0] <= io_rd.i_addr_sid;
      for (int i = 1; i < rd_lat; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_psid[i] <= r_psid[i-1];
      end
    end
  end

  // show-ahead response FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < fifo_depth; i++) begin
        r_md[i] <= '0;
        r_ms[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_md[r_wr] <= w_push_d;
        r_ms[r_wr] <= r_psid[rd_lat-1];
        r_wr       <= f_inc(r_wr);
      end
      if (w_pop) r_rd <= f_inc(r_rd);
      if (w_push & ~w_pop) r_cnt <= r_cnt + cnt_width'(1);
      else if (~w_push & w_pop) r_cnt <= r_cnt - cnt_width'(1);
    end
  end

  a_no_ovf: assert property (@(posedge clk) disable iff (reset)
    !(w_push && w_full && !w_pop));
  a_credit: assert property (@(posedge clk) disable iff (reset)
    r_inflight <= depth_c);
endmodule

// File: tb/tb_l1_rd_rsp.sv
// Directed bench for l1_rd_rsp with BRAM model and in-order scoreboard.
// Define RD_RSP_DISCARD_EN on both RTL and bench to exercise discard.
module tb_l1_rd_rsp;
  localparam int SW  = 6;
  localparam int PW  = 1;
  localparam int DW  = 64;
  localparam int LAT = 2;
  localparam int CW  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  l1_rd_rsp_if #(.nstrms_width(SW), .ptr_width(PW), .data_width(DW)) rd();

  logic          bram_re;
  logic [SW+PW-1:0] bram_addr;
  logic [DW-1:0] bram_d;
  logic [CW-1:0] inflight;

  l1_rd_rsp dut (
    .clk(clk),
    .reset(reset),
    .io_rd(rd),
    .o_bram_re(bram_re),
    .o_bram_addr(bram_addr),
    .i_bram_d(bram_d),
    .o_inflight(inflight)
  );

  function automatic logic [63:0] fdat(input logic [SW+PW-1:0] a);
    return 64'hD000_0000_0000_0000 | 64'(a);
  endfunction

  logic [DW-1:0] bq [LAT];
  always @(posedge clk) begin
    bq[0] <= bram_re ? fdat(bram_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < LAT; i++) bq[i] <= bq[i-1];
  end
  assign bram_d = bq[LAT-1];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_pop = 0;
  int n_v = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic [63:0] q_d [$];
  logic [SW-1:0] q_s [$];
  logic q_x [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic dis;
    #1;
`ifdef RD_RSP_DISCARD_EN
    dis = rd.i_addr_discard;
`else
    dis = 1'b0;
`endif
    if (rd.i_addr_v && rd.i_addr_r) begin
      q_d.push_back(dis ? 64'h0 : fdat({rd.i_addr_sid, rd.i_addr_ptr}));
      q_s.push_back(rd.i_addr_sid);
      q_x.push_back(dis);
      n_acc++;
    end
    if (rd.o_rsp_v) n_v++;
    if (rd.o_rsp_v && rd.o_rsp_r) begin
      if (q_d.size() == 0) begin
        chk("pop_empty", 64'(rd.o_rsp_v), 64'h0);
      end else begin
        chk("rsp_d", rd.o_rsp_d, q_d.pop_front());
        chk("rsp_sid", 64'(rd.o_rsp_sid), 64'(q_s.pop_front()));
        chk("rsp_dis", 64'(rd.o_rsp_discard), 64'(q_x.pop_front()));
      end
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr_sb();
    q_d.delete();
    q_s.delete();
    q_x.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int d0;
    logic [63:0] hold;
    logic [CW-1:0] inf0;
    rd.i_addr_v = 0;
    rd.i_addr_ptr = 0;
    rd.i_addr_sid = 0;
    rd.i_addr_discard = 0;
    rd.o_rsp_r = 0;

    tick();
    tick();
    chk("rst_rdy", 64'(rd.i_addr_r), 64'h0);
    chk("rst_re", 64'(bram_re), 64'h0);
    chk("rst_addr", 64'(bram_addr), 64'h0);
    chk("rst_v", 64'(rd.o_rsp_v), 64'h0);
    chk("rst_d", rd.o_rsp_d, 64'h0);
    chk("rst_sid", 64'(rd.o_rsp_sid), 64'h0);
    chk("rst_dis", 64'(rd.o_rsp_discard), 64'h0);
    chk("rst_inf", 64'(inflight), 64'h0);
    reset = 0;
    tick();
    chk("rdy_after_rst", 64'(rd.i_addr_r), 64'h1);

    rd.i_addr_v = 1;
    rd.i_addr_sid = 6'd5;
    rd.i_addr_ptr = 1'b1;
    #1;
    chk("one_re", 64'(bram_re), 64'h1);
    chk("one_addr", 64'(bram_addr), 64'h0B);
    tick();
    rd.i_addr_v = 0;
    #1;
    chk("idle_addr", 64'(bram_addr), 64'h0);
    chk("one_v_t1", 64'(rd.o_rsp_v), 64'h0);
    tick();
    chk("one_v_t2", 64'(rd.o_rsp_v), 64'h0);
    tick();
    chk("one_v_t3", 64'(rd.o_rsp_v), 64'h1);
    chk("one_sid", 64'(rd.o_rsp_sid), 64'h5);
    chk("one_d", rd.o_rsp_d, 64'hD000_0000_0000_000B);
    chk("one_inf", 64'(inflight), 64'h1);
    rd.o_rsp_r = 1;
    tick();
    chk("one_v_after", 64'(rd.o_rsp_v), 64'h0);
    chk("one_inf_after", 64'(inflight), 64'h0);

    n_pop = 0;
    first_pop = -1;
    rd.i_addr_v = 1;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      rd.i_addr_sid = 6'(i + 8);
      rd.i_addr_ptr = 1'(i);
      chk("strm_rdy", 64'(rd.i_addr_r), 64'h1);
      tick();
    end
    rd.i_addr_v = 0;
    repeat (8) tick();
    chk("strm_cnt", 64'(n_pop), 64'd16);
    chk("strm_lat", 64'(first_pop - t0), 64'd3);
    chk("strm_rate", 64'(last_pop - first_pop), 64'd15);

    rd.o_rsp_r = 0;
    n_acc = 0;
    rd.i_addr_v = 1;
    for (int i = 0; i < 6; i++) begin
      rd.i_addr_sid = 6'(i + 30);
      rd.i_addr_ptr = 1'(i + 1);
      tick();
    end
    rd.i_addr_v = 0;
    repeat (2) tick();
    chk("bp_acc", 64'(n_acc), 64'd4);
    chk("bp_rdy", 64'(rd.i_addr_r), 64'h0);
    chk("bp_inf", 64'(inflight), 64'd4);
    hold = rd.o_rsp_d;
    tick();
    chk("bp_stall_v", 64'(rd.o_rsp_v), 64'h1);
    chk("bp_stall_d", rd.o_rsp_d, hold);
    rd.o_rsp_r = 1;
    tick();
    chk("bp_rdy_back", 64'(rd.i_addr_r), 64'h1);
    repeat (6) tick();
    chk("bp_drain_inf", 64'(inflight), 64'h0);
    chk("bp_drain_q", 64'(q_d.size()), 64'h0);

    rd.o_rsp_r = 0;
    rd.i_addr_v = 1;
    d0 = 0;
    while (rd.i_addr_r && d0 < 8) begin
      rd.i_addr_sid = 6'(d0 + 40);
      tick();
      d0++;
    end
    chk("full_fill", 64'(inflight), 64'd4);
    rd.o_rsp_r = 1;
    rd.i_addr_sid = 6'd50;
    tick();
    for (int i = 0; i < 5; i++) begin
      rd.i_addr_sid = 6'(51 + i);
      inf0 = inflight;
      tick();
      chk("full_inf", 64'(inflight), 64'(inf0));
    end
    rd.i_addr_v = 0;
    repeat (8) tick();
    chk("full_drain_q", 64'(q_d.size()), 64'h0);

    rd.o_rsp_r = 0;
    rd.i_addr_v = 1;
    for (int i = 0; i < 3; i++) begin
      rd.i_addr_sid = 6'(60 + i);
      tick();
    end
    rd.i_addr_v = 0;
    chk("mid_inf", 64'(inflight), 64'd3);
    reset = 1;
    tick();
    chk("mid_rst_v", 64'(rd.o_rsp_v), 64'h0);
    chk("mid_rst_inf", 64'(inflight), 64'h0);
    reset = 0;
    clr_sb();
    n_v = 0;
    rd.o_rsp_r = 1;
    repeat (6) tick();
    chk("mid_no_stale", 64'(n_v), 64'h0);

    n_pop = 0;
    rd.i_addr_v = 1;
    rd.i_addr_sid = 6'd1;
    rd.i_addr_ptr = 1'b0;
    rd.i_addr_discard = 0;
    #1;
    chk("dA_re", 64'(bram_re), 64'h1);
    tick();
    rd.i_addr_sid = 6'd2;
    rd.i_addr_ptr = 1'b1;
    rd.i_addr_discard = 1;
    #1;
`ifdef RD_RSP_DISCARD_EN
    chk("dB_re", 64'(bram_re), 64'h0);
`else
    chk("dB_re", 64'(bram_re), 64'h1);
`endif
    tick();
    rd.i_addr_sid = 6'd3;
    rd.i_addr_ptr = 1'b0;
    rd.i_addr_discard = 0;
    #1;
    chk("dC_re", 64'(bram_re), 64'h1);
    tick();
    rd.i_addr_v = 0;
    repeat (6) tick();
    chk("d_pops", 64'(n_pop), 64'd3);
    chk("d_q", 64'(q_d.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
